imem_ctrl: RTL

//  Arbitrates the single-port synchronous instruction memory between the core fetch port and a

---
 rtl/imem_ctrl.sv | 133 +++++++++++++
 1 files changed

// File: rtl/imem_ctrl.sv
// Instruction memory arbiter: shares one synchronous RAM port between
// the program loader and the core fetch port, holding the core in BOOT.
module imem_ctrl #(
    parameter int          DEPTH    = 1024,
    parameter int          AW       = $clog2(DEPTH),
    parameter int          LOAD_CAP = 4,
    parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          fetch_req,
    input  logic [31:0]   fetch_addr,
    output logic          fetch_gnt,
    output logic          fetch_rvalid,
    output logic [31:0]   fetch_rdata,
    output logic          fetch_err,
    input  logic          load_req,
    input  logic [AW-1:0] load_addr,
    input  logic [31:0]   load_wdata,
    output logic          load_gnt,
    input  logic          load_done,
    output logic          core_hold,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata
);

    localparam int          SW       = $clog2(LOAD_CAP + 1);
    localparam logic [SW-1:0] CAP    = SW'(LOAD_CAP);
    localparam logic [31:0] BYTE_LIM = 32'(DEPTH * 4);

    typedef enum logic {
        BOOT,
        RUN
    } state_e;

    state_e        state_q, state_d;
    logic [SW-1:0] starve_q, starve_d;
    logic          rvalid_q, rvalid_d;
    logic          err_q, err_d;

    logic fetch_legal;
    logic load_win;
    logic fetch_win;

    assign fetch_legal = (fetch_addr[1:0] == 2'b00)
                      && (fetch_addr < BYTE_LIM);

    always_comb begin
        state_d   = state_q;
        starve_d  = starve_q;
        rvalid_d  = 1'b0;
        err_d     = 1'b0;
        load_win  = 1'b0;
        fetch_win = 1'b0;

        if (!rst) begin
            unique case (state_q)
                BOOT: begin
                    load_win = load_req;
                    if (load_done) begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    load_win  = load_req
                             && !(fetch_req && starve_q == CAP);
                    fetch_win = !load_win && fetch_req;
                    // A load beating a waiting fetch implies starve_q < CAP,
                    // so the increment can never run past the cap.
                    if (load_win) begin
                        starve_d = fetch_req ? starve_q + SW'(1) : '0;
                    end else if (fetch_win) begin
                        starve_d = '0;
                    end
                end
            endcase
        end

        if (fetch_win) begin
            rvalid_d = 1'b1;
            err_d    = !fetch_legal;
        end
    end

    always_comb begin
        load_gnt  = load_win;
        fetch_gnt = fetch_win;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;

        if (load_win) begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = load_addr;
            mem_wdata = load_wdata;
        end else if (fetch_win && fetch_legal) begin
            mem_en   = 1'b1;
            mem_addr = fetch_addr[AW+1:2];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= BOOT;
            starve_q <= '0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
        end
    end

    // Masking with rst drops a response whose grant preceded the reset.
    assign fetch_rvalid = rvalid_q && !rst;
    assign fetch_err    = fetch_rvalid && err_q;
    assign core_hold    = rst || (state_q == BOOT);

    always_comb begin
        fetch_rdata = '0;
        if (fetch_rvalid) begin
            fetch_rdata = err_q ? NOP_INSN : mem_rdata;
        end
    end

endmodule
